// File: rtl/mux_feed_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mux_feed_sched_if                                                  |
// | Producer-side and downstream-side signals of the feeder.           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface mux_feed_sched_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  logic [3:0]        i_valid;
  logic [DATA_W-1:0] i_data_0;
  logic [DATA_W-1:0] i_data_1;
  logic [DATA_W-1:0] i_data_2;
  logic [DATA_W-1:0] i_data_3;
  logic [3:0]        o_ready;
  logic [1:0]        o_ctrl;
  logic [DATA_W-1:0] o_data_0;
  logic [DATA_W-1:0] o_data_1;
  logic [DATA_W-1:0] o_data_2;
  logic [DATA_W-1:0] o_data_3;
  logic              o_valid;
  logic              i_ready;
  logic [CNT_W-1:0]  o_xfer_cnt;

  modport slave (
    input  i_valid, i_data_0, i_data_1, i_data_2, i_data_3, i_ready,
    output o_ready, o_ctrl, o_data_0, o_data_1, o_data_2, o_data_3,
           o_valid, o_xfer_cnt
  );

  modport master (
    output i_valid, i_data_0, i_data_1, i_data_2, i_data_3, i_ready,
    input  o_ready, o_ctrl, o_data_0, o_data_1, o_data_2, o_data_3,
           o_valid, o_xfer_cnt
  );
endinterface
`default_nettype wire

// File: rtl/mux_feed_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mux_feed_sched                                                     |
// | Four single-entry slots, round-robin grant to a 4:1 registered mux.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mux_feed_sched #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  wire logic       i_clk,
  input  wire logic       i_rst_n,
  mux_feed_sched_if.slave bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]        r_state;
  logic [3:0]        r_full;
  logic [DATA_W-1:0] r_data [4];
  logic [1:0]        r_ptr;
  logic [1:0]        r_ctrl;
  logic              r_valid;
  logic [CNT_W-1:0]  r_cnt;

  logic [DATA_W-1:0] w_din [4];
  logic [3:0]        w_cap;
  logic [3:0]        w_clr;
  logic              w_done;
  logic              w_any;
  logic [1:0]        w_pick;

  assign w_din[0] = bus.i_data_0;
  assign w_din[1] = bus.i_data_1;
  assign w_din[2] = bus.i_data_2;
  assign w_din[3] = bus.i_data_3;

  // A full slot refuses capture, so capture and release never hit the same slot.
  assign w_cap  = bus.i_valid & ~r_full;
  assign w_done = (r_state == S_GRANT) && bus.i_ready;
  assign w_clr  = w_done ? (4'b0001 << r_ctrl) : 4'b0000;

  always_comb begin
    logic [1:0] idx;
    w_any  = 1'b0;
    w_pick = r_ptr;
    idx    = r_ptr;
    for (int i = 0; i < 4; i++) begin
      idx = r_ptr + 2'(i);
      if (!w_any && r_full[idx]) begin
        w_any  = 1'b1;
        w_pick = idx;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full <= 4'b0000;
      for (int k = 0; k < 4; k++) r_data[k] <= '0;
    end else begin
      r_full <= (r_full & ~w_clr) | w_cap;
      for (int k = 0; k < 4; k++) begin
        if (w_cap[k]) r_data[k] <= w_din[k];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd0;
      r_ctrl  <= 2'd0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_ctrl  <= w_pick;
            r_valid <= 1'b1;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (bus.i_ready) begin
            r_valid <= 1'b0;
            r_ptr   <= r_ctrl + 2'd1;
            r_cnt   <= r_cnt + 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ready    = ~r_full;
  assign bus.o_ctrl     = r_ctrl;
  assign bus.o_valid    = r_valid;
  assign bus.o_xfer_cnt = r_cnt;
  assign bus.o_data_0   = r_data[0];
  assign bus.o_data_1   = r_data[1];
  assign bus.o_data_2   = r_data[2];
  assign bus.o_data_3   = r_data[3];

endmodule
`default_nettype wire

// File: tb/tb_mux_feed_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mux_feed_sched                                                  |
// | Directed vectors with hand-computed expectations, CNT_W = 4.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_mux_feed_sched;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  mux_feed_sched_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  mux_feed_sched #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [15:0] d0, input logic [15:0] d1,
                          input logic [15:0] d2, input logic [15:0] d3);
    bus.i_data_0 = d0;
    bus.i_data_1 = d1;
    bus.i_data_2 = d2;
    bus.i_data_3 = d3;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.i_valid = 4'h0;
    bus.i_ready = 1'b1;
    set_data(16'h0, 16'h0, 16'h0, 16'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single channel 2
    bus.i_valid = 4'b0100;
    set_data(16'h0, 16'h0, 16'h0003, 16'h0);
    tick();
    bus.i_valid = 4'b0000;
    check("single_ready_drop", 32'(bus.o_ready), 32'hB);
    check("single_valid_lo", 32'(bus.o_valid), 32'h0);
    tick();
    check("single_valid_hi", 32'(bus.o_valid), 32'h1);
    check("single_ctrl", 32'(bus.o_ctrl), 32'h2);
    check("single_data2", 32'(bus.o_data_2), 32'h0003);
    tick();
    check("single_done_valid", 32'(bus.o_valid), 32'h0);
    check("single_cnt", 32'(bus.o_xfer_cnt), 32'h1);
    check("single_ready_back", 32'(bus.o_ready), 32'hF);

    // Fairness: pointer is at 3 after channel 2, so 3 goes before 0
    bus.i_valid = 4'b1001;
    set_data(16'h00AA, 16'h0, 16'h0, 16'h00BB);
    tick();
    bus.i_valid = 4'b0000;
    tick();
    check("fair_first_ctrl", 32'(bus.o_ctrl), 32'h3);
    check("fair_first_data", 32'(bus.o_data_3), 32'h00BB);
    tick();
    check("fair_gap_valid", 32'(bus.o_valid), 32'h0);
    tick();
    check("fair_second_ctrl", 32'(bus.o_ctrl), 32'h0);
    check("fair_second_valid", 32'(bus.o_valid), 32'h1);
    tick();
    check("fair_cnt", 32'(bus.o_xfer_cnt), 32'h3);

    // Backpressure on channel 1 while it re-offers a new word
    bus.i_ready = 1'b0;
    bus.i_valid = 4'b0010;
    set_data(16'h0, 16'h0011, 16'h0, 16'h0);
    tick();
    tick();
    check("bp_grant_ctrl", 32'(bus.o_ctrl), 32'h1);
    bus.i_data_1 = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(bus.o_valid), 32'h1);
      check("bp_hold_ctrl", 32'(bus.o_ctrl), 32'h1);
      check("bp_hold_data1", 32'(bus.o_data_1), 32'h0011);
      check("bp_hold_ready1", 32'(bus.o_ready[1]), 32'h0);
    end
    bus.i_valid = 4'b0000;
    bus.i_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(bus.o_valid), 32'h0);
    check("bp_release_cnt", 32'(bus.o_xfer_cnt), 32'h4);
    tick();
    check("bp_one_only_valid", 32'(bus.o_valid), 32'h0);
    check("bp_one_only_cnt", 32'(bus.o_xfer_cnt), 32'h4);

    // Reset to bring the pointer back to 0, then fill all four slots
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.i_valid = 4'b1111;
    set_data(16'h0005, 16'h0004, 16'h0003, 16'h0002);
    tick();
    bus.i_valid = 4'b0000;
    check("all_ready_zero", 32'(bus.o_ready), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("all_grant_valid", 32'(bus.o_valid), 32'h1);
      check("all_grant_ctrl", 32'(bus.o_ctrl), 32'(k));
      tick();
      check("all_gap_valid", 32'(bus.o_valid), 32'h0);
    end
    check("all_data0", 32'(bus.o_data_0), 32'h0005);
    check("all_data3", 32'(bus.o_data_3), 32'h0002);
    check("all_cnt", 32'(bus.o_xfer_cnt), 32'h4);

    // 16 more transfers wrap the 4-bit counter from 4 around to 4
    for (int t = 0; t < 16; t++) begin
      bus.i_valid = 4'b0001 << (t % 4);
      set_data(16'(t), 16'(t), 16'(t), 16'(t));
      tick();
      bus.i_valid = 4'b0000;
      tick();
      tick();
      check("wrap_cnt", 32'(bus.o_xfer_cnt), 32'((t + 5) % 16));
    end

    // Fresh reset, 15 transfers, then the 16th wraps 15 -> 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 16; t++) begin
      bus.i_valid = 4'b1000;
      tick();
      bus.i_valid = 4'b0000;
      tick();
      tick();
      if (t == 14) check("wrap_at_15", 32'(bus.o_xfer_cnt), 32'hF);
    end
    check("wrap_to_0", 32'(bus.o_xfer_cnt), 32'h0);

    // Reset in the middle of a grant, with all channels offering
    bus.i_ready = 1'b0;
    bus.i_valid = 4'b0001;
    set_data(16'h1234, 16'h1234, 16'h1234, 16'h1234);
    tick();
    bus.i_valid = 4'b0000;
    tick();
    check("midgrant_valid_pre", 32'(bus.o_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    bus.i_valid = 4'b1111;
    bus.i_ready = 1'b1;
    #1;
    check("rst_async_valid", 32'(bus.o_valid), 32'h0);
    check("rst_async_cnt", 32'(bus.o_xfer_cnt), 32'h0);
    tick();
    tick();
    check("rst_ready", 32'(bus.o_ready), 32'hF);
    check("rst_ctrl", 32'(bus.o_ctrl), 32'h0);
    check("rst_valid", 32'(bus.o_valid), 32'h0);
    check("rst_cnt", 32'(bus.o_xfer_cnt), 32'h0);
    check("rst_data", 32'({bus.o_data_0, bus.o_data_1} | {bus.o_data_2, bus.o_data_3}), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
